// File: rtl/aes_pkg.sv
// aes_pkg: shared AES GF(2^8) helpers, round constants and the FSM state type
package aes_pkg;
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_e;
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [79:0] t;
    t = 80'h01020408102040801b36 << (8 * i);
    return t[79:72];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/inv_round_128.sv
// inv_round_128: one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last)
module inv_round_128
  import aes_pkg::*;
(
  input  logic [127:0] s,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] s_n
);
  logic [127:0] a, m;
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09),
            gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d),
            gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b),
            gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e)};
  endfunction
  // byte i sits at row i%4, column i/4; row r is rotated right by r columns
  always_comb begin
    a = '0;
    m = '0;
    for (int i = 0; i < 16; i++)
      a[127-8*i -: 8] = inv_sbox(s[127-8*((i%4)+4*(((i/4)-(i%4))&3)) -: 8]) ^ rk[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      m[127-32*c -: 32] = inv_mix_col(a[127-32*c -: 32]);
  end
  assign s_n = last ? a : m;
endmodule

// File: rtl/aes_128_inv_iter.sv
// aes_128_inv_iter: iterative AES-128 decryptor, one round per cycle, with round-10 key cache
module aes_128_inv_iter
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);
  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] s_q, s_d, k_q, k_d, pt_q, pt_d, rk10_q, rk10_d;
  logic [127:0] cache_key_q, cache_key_d, ct_q, ct_d, key_q, key_d;
  logic         out_valid_q, out_valid_d, cache_vld_q, cache_vld_d;
  logic [127:0] kx, rk, rs;
  logic         hit;
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
  assign kx = expand(k_q, rcon(cnt_q));
  assign rk = inv_expand(k_q, rcon(cnt_q));
  assign hit = KEY_CACHE && cache_vld_q && (key == cache_key_q);
  inv_round_128 u_round (.s(s_q), .rk(rk), .last(cnt_q == 4'd0), .s_n(rs));
  // next-state: accept, forward key expansion to round 10, then rounds while unwinding the key
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    s_d = s_q;
    k_d = k_q;
    pt_d = pt_q;
    out_valid_d = out_valid_q;
    cache_vld_d = cache_vld_q;
    rk10_d = rk10_q;
    cache_key_d = cache_key_q;
    ct_d = ct_q;
    key_d = key_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ct_d = ct;
        key_d = key;
        k_d = hit ? rk10_q : key;
        s_d = hit ? ct ^ rk10_q : s_q;
        cnt_d = hit ? 4'd9 : 4'd0;
        state_d = hit ? ROUND : KEXP;
      end
      KEXP: begin
        k_d = kx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          s_d = ct_q ^ kx;
          rk10_d = kx;
          cache_key_d = key_q;
          cache_vld_d = 1'b1;
          cnt_d = 4'd9;
          state_d = ROUND;
        end
      end
      ROUND: begin
        k_d = rk;
        s_d = rs;
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          pt_d = rs;
          out_valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any block in flight and drops the cached key
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      s_q <= '0;
      k_q <= '0;
      pt_q <= '0;
      out_valid_q <= 1'b0;
      cache_vld_q <= 1'b0;
      rk10_q <= '0;
      cache_key_q <= '0;
      ct_q <= '0;
      key_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      k_q <= k_d;
      pt_q <= pt_d;
      out_valid_q <= out_valid_d;
      cache_vld_q <= cache_vld_d;
      rk10_q <= rk10_d;
      cache_key_q <= cache_key_d;
      ct_q <= ct_d;
      key_q <= key_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign pt = pt_q;
endmodule

// File: tb/tb_aes_128_inv_iter.sv
// tb_aes_128_inv_iter: scoreboard bench for the iterative AES-128 decryptor
module tb_aes_128_inv_iter;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [127:0] ct, key, pt, pt0;
  logic [7:0] sb [256];
  logic [127:0] q [$];
  int n_cmp = 0, n_err = 0;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes_128_inv_iter #(.KEY_CACHE(1'b1)) dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready), .pt(pt), .busy(busy));
  aes_128_inv_iter #(.KEY_CACHE(1'b0)) dut0 (.clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .ct(ct), .key(key), .out_valid(out_valid0), .out_ready(out_ready0), .pt(pt0), .busy(busy0));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    while (b != 8'h00) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return gm(a, 8'h02);
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] st, rk;
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3, rc;
    logic [31:0] w, w0, w1, w2, w3;
    rk = k;
    st = p ^ rk;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sb[st[127-8*i -: 8]];
      for (int i = 0; i < 16; i++) t[i] = b[(i%4) + 4*(((i/4)+(i%4))%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      w = rk[31:0];
      w = {sb[w[23:16]] ^ rc, sb[w[15:8]], sb[w[7:0]], sb[w[31:24]]};
      w0 = rk[127:96] ^ w; w1 = rk[95:64] ^ w0; w2 = rk[63:32] ^ w1; w3 = rk[31:0] ^ w2;
      rk = {w0, w1, w2, w3};
      rc = xt(rc);
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i] ^ rk[127-8*i -: 8];
    end
    return st;
  endfunction

  task automatic send(input string tag, input logic [127:0] c, input logic [127:0] k, input logic [127:0] e,
                      input int lat, input int hold, input logic chk_k, input logic [127:0] exp_k);
    int n;
    @(negedge clk);
    ct = c; key = k; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    q.push_back(e);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (chk_k && n == 10) check({tag, "_rk10"}, dut.k_q, exp_k);
    end
    check({tag, "_lat"}, 128'(n), 128'(lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_pt"}, pt, q.size() > 0 ? q[0] : 128'h0);
      check({tag, "_hold_rdy"}, {127'h0, in_ready}, 128'h0);
      check({tag, "_hold_vld"}, {127'h0, out_valid}, 128'h1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    check({tag, "_pt"}, pt, q.size() > 0 ? q.pop_front() : 128'hx);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, {127'h0, in_ready}, 128'h1);
    check({tag, "_vld_after"}, {127'h0, out_valid}, 128'h0);
  endtask

  initial begin
    logic [7:0] v, o, cc;
    logic [127:0] rk_key, rp, rc_, last_key;
    int n;
    cc = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(x[7:0], y[7:0]) == 8'h01) v = y[7:0];
      for (int i = 0; i < 8; i++) o[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ cc[i];
      sb[x] = o;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    ct = '0; key = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_pt", pt, 128'h0);
    check("rst_vld", {127'h0, out_valid}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_rdy", {127'h0, in_ready}, 128'h1);
    check("model_c1", enc(P1, K1), C1);
    send("c1", C1, K1, P1, 20, 0, 1'b0, '0);
    send("b", C2, K2, P2, 20, 0, 1'b1, R2);
    send("b_hit", C2, K2, P2, 10, 0, 1'b0, '0);
    send("bp", C1, K1, P1, 20, 7, 1'b0, '0);
    @(negedge clk);
    ct = C2; key = K2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_pt", pt, 128'h0);
    check("abort_vld", {127'h0, out_valid}, 128'h0);
    check("abort_busy", {127'h0, busy}, 128'h0);
    check("abort_rdy", {127'h0, in_ready}, 128'h1);
    @(negedge clk);
    rst = 1'b0;
    send("post_rst", C2, K2, P2, 20, 0, 1'b0, '0);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      ct = C2; key = K2; in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      n = 0;
      while (out_valid0 !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("nocache_lat", 128'(n), 128'd20);
      check("nocache_pt", pt0, P2);
      @(negedge clk);
      out_ready0 = 1'b1;
      @(posedge clk); #1;
      out_ready0 = 1'b0;
    end
    last_key = K2;
    for (int b = 0; b < 1000; b++) begin
      rk_key = (b > 0 && $urandom_range(0, 3) == 0) ? last_key : {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc_ = enc(rp, rk_key);
      send("rand", rc_, rk_key, rp, (rk_key == last_key) ? 10 : 20, 0, 1'b0, '0);
      last_key = rk_key;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
